// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU issue stage and the ALU itself.
// Holds the ALU func codes, the RV32 opcode/funct fields of the supported
// subset, the decoded-op struct and the issue-stage state encoding.
package alu_pkg;

  localparam int ALU_XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_ADDI = 4'b1011;
  localparam logic [3:0] ALU_ILL  = 4'b1111;

  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [3:0]          func;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic [ALU_XLEN-1:0] imm;
    logic                use_imm;
    logic                we;
    logic                illegal;
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } issue_state_t;

endpackage

// File: rtl/alu_issue_if.sv
// alu_issue_if: instruction-in and decoded-op-out bundle of the issue stage.
// The issue stage takes the master modport (it drives in_ready and the op
// stream); the surrounding fetch/execute environment takes the slave modport.
interface alu_issue_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [XLEN-1:0]  in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_func;
  logic [4:0]       out_rs1;
  logic [4:0]       out_rs2;
  logic [4:0]       out_rd;
  logic [XLEN-1:0]  out_imm;
  logic             out_use_imm;
  logic             out_we;
  logic             out_illegal;
  logic [XLEN-1:0]  out_pc;
  logic [CNT_W-1:0] illegal_cnt;

  modport master (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_func, out_rs1, out_rs2, out_rd,
           out_imm, out_use_imm, out_we, out_illegal, out_pc, illegal_cnt
  );

  modport slave (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_func, out_rs1, out_rs2, out_rd,
           out_imm, out_use_imm, out_we, out_illegal, out_pc, illegal_cnt
  );
endinterface

// File: rtl/alu_issue_dec.sv
// alu_issue_dec: purely combinational RV32 decoder for the supported ALU
// subset (ADD, SUB, AND, OR, XOR, ADDI). Everything else comes out flagged
// illegal with func ALU_ILL and no register write.
module alu_issue_dec
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output alu_op_t     op
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Classify the instruction and build the decoded op; illegal is the default.
  always_comb begin
    op         = '0;
    op.rs1     = instr[19:15];
    op.rs2     = instr[24:20];
    op.rd      = instr[11:7];
    op.func    = ALU_ILL;
    op.illegal = 1'b1;
    case (opcode)
      OP_REG: begin
        if (funct7 == F7_BASE) begin
          case (funct3)
            F3_ADD_SUB: begin op.func = ALU_ADD; op.illegal = 1'b0; end
            F3_AND:     begin op.func = ALU_AND; op.illegal = 1'b0; end
            F3_OR:      begin op.func = ALU_OR;  op.illegal = 1'b0; end
            F3_XOR:     begin op.func = ALU_XOR; op.illegal = 1'b0; end
            default:    op.illegal = 1'b1;
          endcase
        end else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB) begin
          op.func    = ALU_SUB;
          op.illegal = 1'b0;
        end
      end
      OP_IMM: begin
        if (funct3 == F3_ADD_SUB) begin
          op.func    = ALU_ADDI;
          op.illegal = 1'b0;
          op.use_imm = 1'b1;
          op.imm     = {{(ALU_XLEN-12){instr[31]}}, instr[31:20]};
        end
      end
      default: op.illegal = 1'b1;
    endcase
    op.we = ~op.illegal & (op.rd != 5'd0);
  end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: decode/issue stage feeding the ALU. Decodes each accepted
// instruction and queues it in a 2-entry skid buffer (main = output register,
// skid = second entry) so in_ready is registered and independent of out_ready.
// Optional macro ALU_ISSUE_ILLEGAL_CNT_EN builds the saturating illegal-
// instruction counter; without it illegal_cnt is tied to zero.
module alu_issue
  import alu_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int XLEN  = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_issue_if.master bus
);

  issue_state_t    state;
  alu_op_t         dec_op;
  alu_op_t         main_op;
  alu_op_t         skid_op;
  logic [XLEN-1:0] main_pc;
  logic [XLEN-1:0] skid_pc;
  logic            out_valid_q;
  logic            in_ready_q;
  logic            accept;
  logic            fire;

  alu_issue_dec u_dec (
    .instr (bus.in_instr),
    .op    (dec_op)
  );

  assign accept = bus.in_valid & in_ready_q;
  assign fire   = out_valid_q & bus.out_ready;

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_func    = main_op.func;
  assign bus.out_rs1     = main_op.rs1;
  assign bus.out_rs2     = main_op.rs2;
  assign bus.out_rd      = main_op.rd;
  assign bus.out_imm     = main_op.imm;
  assign bus.out_use_imm = main_op.use_imm;
  assign bus.out_we      = main_op.we;
  assign bus.out_illegal = main_op.illegal;
  assign bus.out_pc      = main_pc;

  // Skid-buffer FSM: tracks occupancy and moves ops strictly in FIFO order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      main_op     <= '0;
      skid_op     <= '0;
      main_pc     <= '0;
      skid_pc     <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            main_op     <= dec_op;
            main_pc     <= bus.in_pc;
            out_valid_q <= 1'b1;
            state       <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && fire) begin
            main_op <= dec_op;
            main_pc <= bus.in_pc;
          end else if (accept) begin
            skid_op    <= dec_op;
            skid_pc    <= bus.in_pc;
            in_ready_q <= 1'b0;
            state      <= ST_FULL;
          end else if (fire) begin
            out_valid_q <= 1'b0;
            state       <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (fire) begin
            main_op    <= skid_op;
            main_pc    <= skid_pc;
            in_ready_q <= 1'b1;
            state      <= ST_ONE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= ST_EMPTY;
        end
      endcase
    end
  end

`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
  logic [CNT_W-1:0] illegal_cnt_q;

  // Count accepted illegal instructions, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt_q <= '0;
    end else if (accept && dec_op.illegal && (illegal_cnt_q != {CNT_W{1'b1}})) begin
      illegal_cnt_q <= illegal_cnt_q + 1'b1;
    end
  end

  assign bus.illegal_cnt = illegal_cnt_q;
`else
  assign bus.illegal_cnt = '0;
`endif

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Decode/issue stage that produces the ALU's operation stream: it is the driver side of the ALU func/operand-select interface.
- Accepts 32-bit RV32 instructions over a valid/ready handshake and decodes the supported ALU subset.
- Emits registered ALU func code, register indices, sign-extended immediate and control flags to the execute stage.
- Output is a 2-entry skid buffer, so in_ready is a registered signal and never depends combinationally on out_ready.

Parameters:
- CNT_W, 8, width of the saturating illegal-instruction counter.
- XLEN, 32, data/immediate/pc width (fixed at 32 for RV32).

Ports:
- clk  in  1  Single clock, rising edge.
- rst_n  in  1  Reset, asynchronous, active-low.
- in_valid  in  1  Instruction present.
- in_ready  out  1  Stage can accept an instruction.
- in_instr  in  32  Raw instruction.
- in_pc  in  XLEN  PC of in_instr; passed through unchanged.
- out_valid  out  1  Decoded op present.
- out_ready  in  1  Execute stage accepts the op.
- out_func  out  4  ALU func code.
- out_rs1, out_rs2, out_rd  out  5 each  Register indices (instr[19:15], [24:20], [11:7]).
- out_imm  out  XLEN  Sign-extended I-immediate (instr[31:20]); 0 for R-type.
- out_use_imm  out  1  Operand b is out_imm, not rs2.
- out_we  out  1  Register-file write enable.
- out_illegal  out  1  Instruction not in the supported set.
- out_pc  out  XLEN  Passed-through PC.
- illegal_cnt  out  CNT_W  Saturating count of accepted illegal instructions.

Behaviour:
- Reset (async, rst_n=0): state EMPTY; out_valid=0, in_ready=0 while held; all payload outputs 0; illegal_cnt=0. In-flight entries are dropped.
- Release: in_ready=1 on the first clk edge after rst_n rises.
- Handshake: accept = in_valid & in_ready; fire = out_valid & out_ready. Payload is held stable while out_valid=1 and out_ready=0.
- Latency: an instruction accepted at edge N has out_valid=1 after edge N.
- Decode:
  - opcode 0110011, funct7 0000000: funct3 000 ADD -> 0000; 111 AND -> 0010; 110 OR -> 0011; 100 XOR -> 0100.
  - opcode 0110011, funct7 0100000, funct3 000: SUB -> 0001.
  - opcode 0010011, funct3 000: ADDI -> 1011, use_imm=1.
  - Anything else is illegal: func=1111, we=0, use_imm=0, illegal=1.
- out_we = legal & (rd != 0).
- States (main = output register, skid = second entry):
  - EMPTY (out_valid=0, in_ready=1): accept -> ONE.
  - ONE (out_valid=1, in_ready=1):
    - accept & fire -> ONE; main is loaded with the new op.
    - accept & !fire -> FULL; new op goes to skid.
    - !accept & fire -> EMPTY.
    - otherwise hold.
  - FULL (out_valid=1, in_ready=0): fire -> ONE; skid moves to main. Otherwise hold.
- Ordering is strictly FIFO; no entry is ever lost or duplicated.
- illegal_cnt: increments on accept of an illegal instruction; saturates at all-ones and does not wrap.

Optional Feature:
- Macro: ALU_ISSUE_ILLEGAL_CNT_EN.
- Defined: illegal_cnt counts as specified above.
- Undefined: no counter register is built; illegal_cnt is tied to 0. out_illegal is still generated.

Decomposition:
- Package alu_pkg:
  - func-code localparams (ALU_ADD=0000, ALU_SUB=0001, ALU_AND=0010, ALU_OR=0011, ALU_XOR=0100, ALU_ADDI=1011, ALU_ILL=1111).
  - opcode/funct3/funct7 constants.
  - Packed struct for the decoded op.
- The ALU shares this package.
- One sub-module, alu_issue_dec: purely combinational instr -> decoded struct. The skid buffer and FSM stay in alu_issue.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), out_ready=1 -> next cycle func=0000, rs1=1, rs2=2, rd=3, we=1, use_imm=0, imm=0.
- SUB x5,x6,x7 (0x407302B3) -> func=0001, rd=5, we=1.
- ADDI x1,x0,-1 (0xFFF00093) -> func=1011, imm=0xFFFFFFFF, use_imm=1, rd=1.
- ADD to x0 (0x00208033) -> legal, we=0.
- Illegal 0x00000000 -> func=1111, illegal=1, we=0, illegal_cnt=1.
  - Feed 300 illegals with CNT_W=8 -> illegal_cnt=255 and stays there.
- Backpressure:
  - Hold out_ready=0 and send 3 ops back-to-back -> in_ready drops after the 2nd accept.
  - Release out_ready -> ops emerge in order, one per cycle.
  - Assert rst_n=0 mid-stream -> out_valid=0 immediately, counter=0.
